// File: rtl/stream_fifo_pkg.sv
// Shared defaults and sizing helper for the stream FIFO slice.
package stream_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 128;

    // One extra pointer bit tells full apart from empty when the low bits match.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready byte-stream link; the master drives data/valid and the slave drives ready.
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/stream_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port and one asynchronous read port.
module stream_fifo_ram #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO buffering the decoder's host message streams.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    stream_fifo_if.slave    in_s,
    stream_fifo_if.master   out_m
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ptr_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;

    // Flags come only from registered pointers, so no input combinationally reaches the other side.
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // Ready is held low for as long as reset is asserted.
    assign in_s.ready  = reset && !full_c;
    assign out_m.valid = !empty_c;
    assign out_m.data  = empty_c ? '0 : rd_data;

    assign push_c = in_s.valid && in_s.ready;
    assign pop_c  = out_m.valid && out_m.ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    stream_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (in_s.data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo against a queue-based reference model.
module tb_stream_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 128;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    stream_fifo_if #(.WIDTH(WIDTH)) in_if ();
    stream_fifo_if #(.WIDTH(WIDTH)) out_if ();

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .in_s  (in_if),
        .out_m (out_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a plain queue.
    logic [WIDTH-1:0] mq [$];

    function automatic logic m_ready();
        return reset && (mq.size() < int'(DEPTH));
    endfunction

    function automatic logic m_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [WIDTH-1:0] m_data();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    // Drive one cycle of stimulus, then apply the handshakes to the model at the edge.
    task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic r);
        logic do_push;
        logic do_pop;
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = r;
        do_push = v && m_ready();
        do_pop  = r && m_valid();
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_if.valid  = 1'b1;
        in_if.data   = 8'h3C;
        out_if.ready = 1'b0;
        reset        = 1'b0;
        mq.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (in_if.ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold ready: got %b want 0", in_if.ready);
            end
            checks++;
            if (out_if.valid !== 1'b0 || out_if.data !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold out: got valid %b data %h want 0/00", out_if.valid, out_if.data);
            end
        end
        in_if.valid = 1'b0;
        reset       = 1'b1;
        #1;
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ready: got %b want 1", in_if.ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (out_if.valid !== m_valid() || out_if.data !== m_data()) begin
                errors++;
                $display("FAIL reset_empty: got valid %b data %h want %b %h",
                         out_if.valid, out_if.data, m_valid(), m_data());
            end
        end
    endtask

    task automatic test_single_word();
        tick(1'b1, 8'hA5, 1'b0);
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== 8'hA5) begin
            errors++;
            $display("FAIL single_push: got valid %b data %h want 1 a5", out_if.valid, out_if.data);
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_if.valid !== 1'b0 || out_if.data !== 8'h00) begin
            errors++;
            $display("FAIL single_pop: got valid %b data %h want 0 00", out_if.valid, out_if.data);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < int'(DEPTH); i++) begin
            checks++;
            if (in_if.ready !== m_ready()) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b want %b", i, in_if.ready, m_ready());
            end
            tick(1'b1, 8'(i), 1'b0);
        end
        checks++;
        if (in_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got ready %b want 0", in_if.ready);
        end
        tick(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== m_data()) begin
                errors++;
                $display("FAIL fill_drain[%0d]: got valid %b data %h want 1 %h",
                         i, out_if.valid, out_if.data, m_data());
            end
            tick(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_end: got valid %b ready %b want 0 1", out_if.valid, in_if.ready);
        end
    endtask

    task automatic test_streaming();
        tick(1'b1, 8'h00, 1'b1);
        for (int i = 1; i < 300; i++) begin
            checks++;
            if (out_if.valid !== 1'b1 || in_if.ready !== 1'b1 || out_if.data !== 8'(i - 1)) begin
                errors++;
                $display("FAIL stream[%0d]: got valid %b ready %b data %h want 1 1 %h",
                         i, out_if.valid, in_if.ready, out_if.data, 8'(i - 1));
            end
            tick(1'b1, 8'(i), 1'b1);
        end
        checks++;
        if (out_if.data !== m_data() || mq.size() != 1) begin
            errors++;
            $display("FAIL stream_tail: got data %h want %h", out_if.data, m_data());
        end
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < int'(DEPTH); i++) tick(1'b1, 8'($urandom), 1'b0);
        checks++;
        if (in_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_full: got ready %b want 0", in_if.ready);
        end
        tick(1'b1, 8'h55, 1'b1);
        checks++;
        if (in_if.ready !== 1'b1 || mq.size() != int'(DEPTH) - 1) begin
            errors++;
            $display("FAIL fullpop_refused: got ready %b want 1", in_if.ready);
        end
        tick(1'b1, 8'h55, 1'b0);
        checks++;
        if (in_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_accept: got ready %b want 0", in_if.ready);
        end
        while (mq.size() != 0) begin
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== m_data()) begin
                errors++;
                $display("FAIL fullpop_drain: got valid %b data %h want 1 %h",
                         out_if.valid, out_if.data, m_data());
            end
            if (mq.size() == 1) begin
                checks++;
                if (out_if.data !== 8'h55) begin
                    errors++;
                    $display("FAIL fullpop_last: got %h want 55", out_if.data);
                end
            end
            tick(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_decoder_frame();
        logic [WIDTH-1:0] frame [5];
        int               idx;
        for (int i = 0; i < 5; i++) frame[i] = 8'($urandom);
        idx = 0;
        while (idx < 5) begin
            if ($urandom_range(0, 2) != 0) begin
                tick(1'b1, frame[idx], 1'b0);
                idx++;
            end else begin
                tick(1'b0, 8'($urandom), 1'b0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== frame[i]) begin
                errors++;
                $display("FAIL frame_byte[%0d]: got valid %b data %h want 1 %h",
                         i, out_if.valid, out_if.data, frame[i]);
            end
            tick(1'b0, 8'h00, 1'b1);
        end
        tick(1'b1, frame[0], 1'b0);
        tick(1'b1, frame[1], 1'b0);
        in_if.valid = 1'b1;
        in_if.data  = frame[2];
        reset       = 1'b0;
        mq.delete();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_if.ready !== 1'b0 || out_if.valid !== 1'b0 || out_if.data !== 8'h00) begin
            errors++;
            $display("FAIL frame_reset: got ready %b valid %b data %h want 0 0 00",
                     in_if.ready, out_if.valid, out_if.data);
        end
        in_if.valid = 1'b0;
        reset       = 1'b1;
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (in_if.ready !== 1'b1 || out_if.valid !== 1'b0 || out_if.data !== 8'h00) begin
            errors++;
            $display("FAIL frame_after_reset: got ready %b valid %b data %h want 1 0 00",
                     in_if.ready, out_if.valid, out_if.data);
        end
    endtask

    task automatic test_random_traffic();
        int pv;
        int pr;
        for (int i = 0; i < 3000; i++) begin
            pv = (i / 500) % 2 == 0 ? 3 : 1;
            pr = (i / 500) % 2 == 0 ? 1 : 3;
            checks++;
            if (in_if.ready !== m_ready() || out_if.valid !== m_valid() || out_if.data !== m_data()) begin
                errors++;
                $display("FAIL random[%0d]: got ready %b valid %b data %h want %b %b %h",
                         i, in_if.ready, out_if.valid, out_if.data, m_ready(), m_valid(), m_data());
            end
            tick(1'($urandom_range(0, 3) < pv), 8'($urandom), 1'($urandom_range(0, 3) < pr));
        end
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        test_reset();
        test_single_word();
        test_fill();
        test_streaming();
        test_full_pop();
        test_decoder_frame();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
